// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port ROM arbiter.
package rom_arb_pkg;

  localparam logic PORT_A        = 1'b0;
  localparam logic PORT_B        = 1'b1;
  localparam logic ROM_CS_ACTIVE = 1'b0;

  // One in-flight ROM access, tracked until its response is steered back.
  typedef struct packed {
    logic valid;
    logic port;
    logic err;
  } tag_t;

endpackage

// File: rtl/rom_arb_rr.sv
// Two-way round-robin picker: combinational, the caller registers last_grant.
module rom_arb_rr
  import rom_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Lone requester always wins; on contention the port not served last wins.
  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b00: grant = 2'b00;
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: grant = (last_grant == PORT_B) ? 2'b01 : 2'b10;
    endcase
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one single-port ROM between an instruction port (A) and a data port (B).
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req_valid,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  output logic                  a_req_ready,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_data,
  output logic                  a_rsp_err,
  input  logic                  b_req_valid,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  output logic                  b_req_ready,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_data,
  output logic                  b_rsp_err,
  output logic                  rom_cs,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  // One extra bit so the range compare is a plain unsigned compare at any width.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [1:0]            req_valid;
  logic [1:0]            grant;
  logic                  last_grant_q;
  logic                  any_grant;
  logic                  win_port;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  win_oor;
  tag_t                  tag_d;
  tag_t                  tag_q [ROM_LATENCY];
  tag_t                  tag_out;
  logic                  rsp_live;

  // Nothing is granted while reset is held.
  assign req_valid = {b_req_valid, a_req_valid} & {2{~rst}};

  rom_arb_rr u_rr (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign any_grant   = |grant;
  assign win_port    = grant[1] ? PORT_B : PORT_A;
  assign win_addr    = grant[1] ? b_req_addr : a_req_addr;
  assign win_oor     = ({1'b0, win_addr} >= DEPTH_EXT);
  assign a_req_ready = grant[0];
  assign b_req_ready = grant[1];

  // Out-of-range grants are still accepted but never reach the ROM.
  always_comb begin
    rom_cs   = ~ROM_CS_ACTIVE;
    rom_addr = '0;
    if (any_grant && !win_oor) begin
      rom_cs   = ROM_CS_ACTIVE;
      rom_addr = win_addr;
    end
  end

  // Remember the winner so the other port takes the next contended cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= PORT_B;
    end else if (any_grant) begin
      last_grant_q <= win_port;
    end
  end

  assign tag_d = '{valid: any_grant, port: win_port, err: win_oor};

  // Tag pipeline matches the ROM read latency; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_d;
      for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out  = tag_q[ROM_LATENCY-1];
  assign rsp_live = tag_out.valid && !rst;

  // Steer the ROM word to whichever port owns the tag leaving the pipeline.
  always_comb begin
    a_rsp_valid = rsp_live && (tag_out.port == PORT_A);
    b_rsp_valid = rsp_live && (tag_out.port == PORT_B);
    a_rsp_err   = a_rsp_valid && tag_out.err;
    b_rsp_err   = b_rsp_valid && tag_out.err;
    a_rsp_data  = (a_rsp_valid && !tag_out.err) ? rom_data : '0;
    b_rsp_data  = (b_rsp_valid && !tag_out.err) ? rom_data : '0;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: one ROM_LATENCY=1 and one ROM_LATENCY=3 instance share stimulus.
module tb_rom_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req_valid, b_req_valid;
  logic [15:0] a_req_addr, b_req_addr;

  logic        a_rdy1, a_rv1, a_re1, b_rdy1, b_rv1, b_re1, rom_cs1;
  logic [31:0] a_rd1, b_rd1, rom_data1;
  logic [15:0] rom_addr1;
  logic        a_rdy3, a_rv3, a_re3, b_rdy3, b_rv3, b_re3, rom_cs3;
  logic [31:0] a_rd3, b_rd3, rom_data3;
  logic [15:0] rom_addr3;
  logic [31:0] rom3_p0, rom3_p1;

  int nchecks = 0;
  int nerr    = 0;
  int cyc     = 0;

  rom_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(16), .ROM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_addr(a_req_addr), .a_req_ready(a_rdy1),
    .a_rsp_valid(a_rv1), .a_rsp_data(a_rd1), .a_rsp_err(a_re1),
    .b_req_valid(b_req_valid), .b_req_addr(b_req_addr), .b_req_ready(b_rdy1),
    .b_rsp_valid(b_rv1), .b_rsp_data(b_rd1), .b_rsp_err(b_re1),
    .rom_cs(rom_cs1), .rom_addr(rom_addr1), .rom_data(rom_data1)
  );

  rom_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(16), .ROM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_addr(a_req_addr), .a_req_ready(a_rdy3),
    .a_rsp_valid(a_rv3), .a_rsp_data(a_rd3), .a_rsp_err(a_re3),
    .b_req_valid(b_req_valid), .b_req_addr(b_req_addr), .b_req_ready(b_rdy3),
    .b_rsp_valid(b_rv3), .b_rsp_data(b_rd3), .b_rsp_err(b_re3),
    .rom_cs(rom_cs3), .rom_addr(rom_addr3), .rom_data(rom_data3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM stand-ins: word i holds 0x1000_0000 + i; unselected reads return junk.
  always @(posedge clk) begin
    rom_data1 <= (rom_cs1 == 1'b0) ? (32'h1000_0000 + 32'(rom_addr1)) : 32'hDEAD_BEEF;
    rom3_p0   <= (rom_cs3 == 1'b0) ? (32'h1000_0000 + 32'(rom_addr3)) : 32'hDEAD_BEEF;
    rom3_p1   <= rom3_p0;
    rom_data3 <= rom3_p1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          v;
    bit          port;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  rsp_t sched [2][1024];
  int   lat   [2] = '{1, 3};
  bit   mlast;

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 1024; c++) sched[k][c] = '{0, 0, 0, 32'h0};
    end
    mlast = 1'b1;
    forever begin
      bit          ga, gb, oor;
      logic [15:0] addr;
      rsp_t        e;
      @(negedge clk);
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          for (int c = 0; c <= 3; c++) sched[k][cyc+c] = '{0, 0, 0, 32'h0};
        end
      end
      ga = 1'b0;
      gb = 1'b0;
      if (!rst) begin
        if (a_req_valid && b_req_valid) begin
          if (mlast) ga = 1'b1;
          else       gb = 1'b1;
        end else begin
          ga = a_req_valid;
          gb = b_req_valid;
        end
      end
      addr = ga ? a_req_addr : b_req_addr;
      oor  = (int'(addr) >= 16);

      for (int k = 0; k < 2; k++) begin
        logic        ar, br, cs, av, ae, bv, be;
        logic [15:0] ra;
        logic [31:0] ad, bd;
        string       t;
        t  = (k == 0) ? "L1" : "L3";
        ar = (k == 0) ? a_rdy1 : a_rdy3;
        br = (k == 0) ? b_rdy1 : b_rdy3;
        cs = (k == 0) ? rom_cs1 : rom_cs3;
        ra = (k == 0) ? rom_addr1 : rom_addr3;
        av = (k == 0) ? a_rv1 : a_rv3;
        ad = (k == 0) ? a_rd1 : a_rd3;
        ae = (k == 0) ? a_re1 : a_re3;
        bv = (k == 0) ? b_rv1 : b_rv3;
        bd = (k == 0) ? b_rd1 : b_rd3;
        be = (k == 0) ? b_re1 : b_re3;
        e  = sched[k][cyc];
        check({t, " a_req_ready"}, 64'(ar), 64'(ga));
        check({t, " b_req_ready"}, 64'(br), 64'(gb));
        check({t, " rom_cs"}, 64'(cs), ((ga || gb) && !oor) ? 64'd0 : 64'd1);
        check({t, " rom_addr"}, 64'(ra), ((ga || gb) && !oor) ? 64'(addr) : 64'd0);
        check({t, " a_rsp {valid,err,data}"}, {31'b0, av, ae, ad},
              (e.v && !e.port) ? {31'b0, 1'b1, e.err, e.data} : 64'd0);
        check({t, " b_rsp {valid,err,data}"}, {31'b0, bv, be, bd},
              (e.v && e.port) ? {31'b0, 1'b1, e.err, e.data} : 64'd0);
        if (ga || gb) begin
          sched[k][cyc+lat[k]] = '{1, gb, oor, oor ? 32'h0 : 32'h1000_0000 + 32'(addr)};
        end
      end

      if (rst)     mlast = 1'b1;
      else if (ga) mlast = 1'b0;
      else if (gb) mlast = 1'b1;
      cyc++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input bit av, input logic [15:0] aa, input bit bv, input logic [15:0] ba,
                       input bit r);
    @(posedge clk);
    #1;
    a_req_valid = av;
    a_req_addr  = aa;
    b_req_valid = bv;
    b_req_addr  = ba;
    rst         = r;
  endtask

  initial begin
    rst         = 1'b1;
    a_req_valid = 1'b0;
    a_req_addr  = '0;
    b_req_valid = 1'b0;
    b_req_addr  = '0;

    // Reset with requests pending: nothing granted, ROM idle.
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 1, 0, 1);
    #2;
    check("lit reset a_req_ready", 64'(a_rdy1), 64'd0);
    check("lit reset rom_cs", 64'(rom_cs1), 64'd1);

    // A alone streams addresses 0..9.
    for (int i = 0; i < 10; i++) begin
      drive(1, 16'(i), 0, 0, 0);
      if (i == 0) begin
        #2;
        check("lit A first ready", 64'(a_rdy1), 64'd1);
        check("lit A first rom_cs", 64'(rom_cs1), 64'd0);
      end
    end
    drive(0, 0, 0, 0, 0);
    #2;
    check("lit A last rsp_data", 64'(a_rd1), 64'h1000_0009);
    check("lit A last rsp_valid", 64'(a_rv1), 64'd1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);

    // Contention after reset: A first, then strict alternation.
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      drive(1, 3, 1, 7, 0);
      if (i == 0) begin
        #2;
        check("lit contend first a_ready", 64'(a_rdy1), 64'd1);
        check("lit contend first b_ready", 64'(b_rdy1), 64'd0);
      end else if (i == 1) begin
        #2;
        check("lit contend second b_ready", 64'(b_rdy1), 64'd1);
        check("lit contend a_rsp_data", 64'(a_rd1), 64'h1000_0003);
      end
    end
    drive(0, 0, 0, 0, 0);

    // Range boundary on B: 16 is rejected with an error, 15 reads the last word.
    drive(0, 0, 1, 16, 0);
    #2;
    check("lit oor b_ready", 64'(b_rdy1), 64'd1);
    check("lit oor rom_cs", 64'(rom_cs1), 64'd1);
    drive(0, 0, 1, 15, 0);
    #2;
    check("lit oor b_rsp {valid,err,data}", {31'b0, b_rv1, b_re1, b_rd1}, {31'b0, 2'b11, 32'h0});
    drive(0, 0, 0, 0, 0);
    #2;
    check("lit addr15 b_rsp {valid,err,data}", {31'b0, b_rv1, b_re1, b_rd1},
          {31'b0, 2'b10, 32'h1000_000F});

    // Contention with an out-of-range A address.
    drive(1, 16'hFFFF, 1, 2, 0);
    drive(1, 16'hFFFF, 1, 2, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Reset right after an A accept drops its response.
    drive(1, 4, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    #2;
    check("lit flush a_rsp_valid", 64'(a_rv1), 64'd0);
    check("lit flush rom_cs", 64'(rom_cs1), 64'd1);
    drive(1, 1, 1, 2, 0);
    #2;
    check("lit post-reset a_ready", 64'(a_rdy1), 64'd1);
    drive(0, 0, 1, 2, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);

    // Back-to-back A then B, observed on the latency-3 instance.
    drive(1, 5, 0, 0, 0);
    drive(0, 0, 1, 9, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    #2;
    check("lit L3 a_rsp {valid,data}", {31'b0, a_rv3, a_rd3}, {31'b0, 1'b1, 32'h1000_0005});
    drive(0, 0, 0, 0, 0);
    #2;
    check("lit L3 b_rsp {valid,data}", {31'b0, b_rv3, b_rd3}, {31'b0, 1'b1, 32'h1000_0009});
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares one single_port_rom instance between two requesters: port A (instruction fetch) and port B (data/table load).
- Each cycle, a round-robin picker grants at most one ROM access and drives the ROM chip select (active-low) and address.
- The ROM's registered read data is steered back to the port that issued the access, with a fixed latency.
- Addresses at or beyond DEPTH are never issued to the ROM; they complete with an error response.

Parameters:
- ADDR_WIDTH, 16, requester and ROM address width
- DATA_WIDTH, 32, ROM word width
- DEPTH, 16, number of valid ROM words; addr >= DEPTH is out of range
- ROM_LATENCY, 1, cycles from the sampling edge of rom_cs low to valid rom_data (>=1)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- a_req_valid  in  1  port A request
- a_req_addr  in  ADDR_WIDTH  port A word address
- a_req_ready  out  1  port A request accepted this cycle (combinational)
- a_rsp_valid  out  1  port A response valid, one-cycle pulse
- a_rsp_data  out  DATA_WIDTH  port A read data
- a_rsp_err  out  1  port A out-of-range address
- b_req_valid, b_req_addr, b_req_ready, b_rsp_valid, b_rsp_data, b_rsp_err: same as port A, for port B
- rom_cs  out  1  ROM chip select, active-low, combinational
- rom_addr  out  ADDR_WIDTH  ROM address, combinational
- rom_data  in  DATA_WIDTH  ROM read data

Behaviour:
- Reset (rst=1 at posedge): last_grant=B, so A wins first.
  - Reset flushes all in-flight tags; responses are dropped.
  - From the cycle after reset: a/b_rsp_valid=0, a/b_rsp_err=0, a/b_rsp_data=0.
  - While rst=1: rom_cs=1, a/b_req_ready=0.
- Arbitration (combinational, every cycle):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the port that is not last_grant.
  - last_grant updates to the winner on the clock edge.
- Handshake: the transfer occurs in a cycle where req_valid and req_ready are both 1.
  - req_ready is 0 for the loser and for idle ports.
  - The requester holds valid/addr until accepted; address stability before acceptance is not checked.
- ROM drive:
  - In-range granted cycle: rom_cs=0, rom_addr=winner addr.
  - Otherwise: rom_cs=1, rom_addr=0.
  - Out-of-range grant: rom_cs=1, ready still asserted.
- Tag pipeline: ROM_LATENCY-deep shift register of {valid, port, err}, loaded at the accept edge.
- Response: the tag at the end of the pipeline asserts exactly one rsp_valid in cycle N+ROM_LATENCY after accept cycle N.
  - In-range: rsp_data=rom_data, err=0.
  - Out-of-range: rsp_data=0, err=1.
  - Non-target port: rsp_valid=0, data 0.
- Responses register the rom_data passthrough combinationally only via the tag mux; there is no output buffering and responses cannot be back-pressured.
- Throughput: one accept per cycle, fully pipelined. Back-to-back grants alternate A/B when both are held valid.
- Per-port responses return in acceptance order.
- Range check: addr >= DEPTH, unsigned, full ADDR_WIDTH compare.

Decomposition:
- Package rom_arb_pkg:
  - PORT_A=0, PORT_B=1
  - ROM_CS_ACTIVE=1'b0
  - tag struct {valid, port, err}
- Sub-module rom_arb_rr: 2-way round-robin picker.
  - Inputs: valid[1:0], last_grant.
  - Outputs: one-hot grant.
  - Pure combinational; rom_arbiter registers last_grant.

Test Plan:
- A only, addr 0..9 on consecutive cycles, ROM word i = 0x1000_0000+i -> a_req_ready=1 every cycle; a_rsp_valid 1 cycle after each accept with data 0x1000_0000+i; b_rsp_valid never 1.
- A and B both valid continuously, A addr 3, B addr 7 -> grants A,B,A,B starting with A after reset; rsp alternate with 0x1000_0003 / 0x1000_0007; no accept lost or duplicated.
- B addr 16 (DEPTH=16) -> b_req_ready=1, rom_cs stays 1 that cycle, b_rsp_valid=1 and b_rsp_err=1 with data 0 one cycle later; addr 15 -> err=0, data 0x1000_000F.
- rst pulsed for 1 cycle in the cycle after an A accept -> no a_rsp_valid appears; rom_cs=1; first post-reset contention grants A.
- ROM_LATENCY=3 build, A then B back-to-back -> a_rsp_valid at accept+3, b_rsp_valid the next cycle, data matches addresses.
